// File: rtl/rs_age_ordered.sv
// rs_age_ordered: reservation station with CDB wakeup, dispatch-time forwarding and
// oldest-ready issue to the ALU through a held valid/ready output register.
module rs_age_ordered #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int OPT_W  = 6,
  parameter int CDB_N  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [OPT_W-1:0]          disp_op,
  input  logic [TAG_W-1:0]          disp_dest,
  input  logic [TAG_W-1:0]          disp_qi,
  input  logic [TAG_W-1:0]          disp_qj,
  input  logic [DATA_W-1:0]         disp_vi,
  input  logic [DATA_W-1:0]         disp_vj,
  input  logic [DATA_W-1:0]         disp_imm,
  input  logic [DATA_W-1:0]         disp_pc,
  input  logic [CDB_N-1:0]          cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]    cdb_tag,
  input  logic [CDB_N*DATA_W-1:0]   cdb_data,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [OPT_W-1:0]          iss_op,
  output logic [TAG_W-1:0]          iss_dest,
  output logic [DATA_W-1:0]         iss_vi,
  output logic [DATA_W-1:0]         iss_vj,
  output logic [DATA_W-1:0]         iss_imm,
  output logic [DATA_W-1:0]         iss_pc,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int RW = $clog2(DEPTH);
  localparam int CW = RW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic              r_busy [DEPTH];
  logic [OPT_W-1:0]  r_op   [DEPTH];
  logic [TAG_W-1:0]  r_dest [DEPTH];
  logic [TAG_W-1:0]  r_qi   [DEPTH];
  logic [TAG_W-1:0]  r_qj   [DEPTH];
  logic [DATA_W-1:0] r_vi   [DEPTH];
  logic [DATA_W-1:0] r_vj   [DEPTH];
  logic [DATA_W-1:0] r_imm  [DEPTH];
  logic [DATA_W-1:0] r_pc   [DEPTH];
  logic [RW-1:0]     r_rank [DEPTH];
  logic              w_cv [CDB_N];
  logic [TAG_W-1:0]  w_ct [CDB_N];
  logic [DATA_W-1:0] w_cd [CDB_N];
  logic [TAG_W-1:0]  w_qi [DEPTH];
  logic [TAG_W-1:0]  w_qj [DEPTH];
  logic [DATA_W-1:0] w_vi [DEPTH];
  logic [DATA_W-1:0] w_vj [DEPTH];
  logic [TAG_W-1:0]  w_fqi, w_fqj;
  logic [DATA_W-1:0] w_fvi, w_fvj;
  logic [RW-1:0]     w_free, w_sel, w_sel_rank, w_new_rank;
  logic              w_any, w_alloc, w_adv, w_issue;
  // tag 0 means "no dependency", so a broadcast of tag 0 never matches anything
  for (genvar k = 0; k < CDB_N; k++) begin : g_cdb
    assign w_ct[k] = cdb_tag[k*TAG_W +: TAG_W];
    assign w_cd[k] = cdb_data[k*DATA_W +: DATA_W];
    assign w_cv[k] = cdb_valid[k] && w_ct[k] != '0;
  end
  assign disp_ready = count < FULL;
  assign w_alloc    = disp_valid && disp_ready;
  assign w_adv      = !iss_valid || iss_ready;
  assign w_issue    = w_adv && w_any;
  assign w_new_rank = RW'(count - CW'(w_issue));
  always_comb begin
    w_fqi = disp_qi;
    w_fqj = disp_qj;
    w_fvi = disp_vi;
    w_fvj = disp_vj;
    for (int p = CDB_N - 1; p >= 0; p--) begin
      if (w_cv[p] && w_ct[p] == disp_qi) begin
        w_fqi = '0;
        w_fvi = w_cd[p];
      end
      if (w_cv[p] && w_ct[p] == disp_qj) begin
        w_fqj = '0;
        w_fvj = w_cd[p];
      end
    end
  end
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_qi[i] = r_qi[i];
      w_qj[i] = r_qj[i];
      w_vi[i] = r_vi[i];
      w_vj[i] = r_vj[i];
      for (int p = CDB_N - 1; p >= 0; p--) begin
        if (w_cv[p] && w_ct[p] == r_qi[i]) begin
          w_qi[i] = '0;
          w_vi[i] = w_cd[p];
        end
        if (w_cv[p] && w_ct[p] == r_qj[i]) begin
          w_qj[i] = '0;
          w_vj[i] = w_cd[p];
        end
      end
    end
  end
  always_comb begin
    w_free     = '0;
    w_sel      = '0;
    w_sel_rank = '0;
    w_any      = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!r_busy[i]) w_free = RW'(i);
    for (int i = 0; i < DEPTH; i++)
      if (r_busy[i] && r_qi[i] == '0 && r_qj[i] == '0 && (!w_any || r_rank[i] < w_sel_rank)) begin
        w_any      = 1'b1;
        w_sel      = RW'(i);
        w_sel_rank = r_rank[i];
      end
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count     <= '0;
      iss_valid <= 1'b0;
      iss_op    <= '0;
      iss_dest  <= '0;
      iss_vi    <= '0;
      iss_vj    <= '0;
      iss_imm   <= '0;
      iss_pc    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_busy[i] <= 1'b0;
        r_rank[i] <= '0;
      end
    end else if (rdy) begin
      count <= (w_alloc && !w_issue) ? count + 1'b1 : (!w_alloc && w_issue) ? count - 1'b1 : count;
      if (w_adv) iss_valid <= w_any;
      if (w_issue) begin
        iss_op   <= r_op[w_sel];
        iss_dest <= r_dest[w_sel];
        iss_vi   <= r_vi[w_sel];
        iss_vj   <= r_vj[w_sel];
        iss_imm  <= r_imm[w_sel];
        iss_pc   <= r_pc[w_sel];
      end
      // the free slot is chosen from pre-edge state, so a slot issuing now is never reused this edge
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc && w_free == RW'(i)) begin
          r_busy[i] <= 1'b1;
          r_op[i]   <= disp_op;
          r_dest[i] <= disp_dest;
          r_qi[i]   <= w_fqi;
          r_qj[i]   <= w_fqj;
          r_vi[i]   <= w_fvi;
          r_vj[i]   <= w_fvj;
          r_imm[i]  <= disp_imm;
          r_pc[i]   <= disp_pc;
          r_rank[i] <= w_new_rank;
        end else if (r_busy[i]) begin
          r_busy[i] <= !(w_issue && w_sel == RW'(i));
          r_qi[i]   <= w_qi[i];
          r_qj[i]   <= w_qj[i];
          r_vi[i]   <= w_vi[i];
          r_vj[i]   <= w_vj[i];
          if (w_issue && r_rank[i] > w_sel_rank) r_rank[i] <= r_rank[i] - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_age_ordered.sv
// tb_rs_age_ordered: scoreboard bench; expected issues are queued at dispatch and popped on each handshake.
module tb_rs_age_ordered;
  localparam int DEPTH = 16, TAG_W = 4, DATA_W = 32, OPT_W = 6, CDB_N = 2;
  logic                    clk = 1'b0;
  logic                    rst, rdy, flush, disp_valid, disp_ready, iss_valid, iss_ready;
  logic [OPT_W-1:0]        disp_op, iss_op;
  logic [TAG_W-1:0]        disp_dest, disp_qi, disp_qj, iss_dest;
  logic [DATA_W-1:0]       disp_vi, disp_vj, disp_imm, disp_pc, iss_vi, iss_vj, iss_imm, iss_pc;
  logic [CDB_N-1:0]        cdb_valid;
  logic [CDB_N*TAG_W-1:0]  cdb_tag;
  logic [CDB_N*DATA_W-1:0] cdb_data;
  logic [4:0]              count;
  typedef struct packed {
    logic [OPT_W-1:0]  op;
    logic [TAG_W-1:0]  dest;
    logic [DATA_W-1:0] vi, vj, imm, pc;
  } exp_t;
  exp_t q[$];
  exp_t m_e;
  int n_tests = 0, n_fail = 0;
  rs_age_ordered #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OPT_W(OPT_W), .CDB_N(CDB_N)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_dest(disp_dest),
    .disp_qi(disp_qi), .disp_qj(disp_qj), .disp_vi(disp_vi), .disp_vj(disp_vj),
    .disp_imm(disp_imm), .disp_pc(disp_pc),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_dest(iss_dest),
    .iss_vi(iss_vi), .iss_vj(iss_vj), .iss_imm(iss_imm), .iss_pc(iss_pc), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [DATA_W-1:0] imm_of(input logic [TAG_W-1:0] d);
    return 32'h1000 + 32'(d);
  endfunction
  function automatic logic [DATA_W-1:0] pc_of(input logic [TAG_W-1:0] d);
    return 32'h8000_0000 | (32'(d) << 2);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic disp(input logic [5:0] op, input logic [3:0] dest, input logic [3:0] qi, input logic [3:0] qj,
                      input logic [31:0] vi, input logic [31:0] vj);
    disp_valid = 1'b1;
    disp_op = op; disp_dest = dest; disp_qi = qi; disp_qj = qj; disp_vi = vi; disp_vj = vj;
    disp_imm = imm_of(dest);
    disp_pc = pc_of(dest);
    step();
    disp_valid = 1'b0;
  endtask
  task automatic expect_iss(input logic [5:0] op, input logic [3:0] dest, input logic [31:0] vi, input logic [31:0] vj);
    exp_t e;
    e.op = op; e.dest = dest; e.vi = vi; e.vj = vj; e.imm = imm_of(dest); e.pc = pc_of(dest);
    q.push_back(e);
  endtask
  task automatic cdb_set(input int p, input logic [3:0] tag, input logic [31:0] d);
    cdb_valid[p] = 1'b1;
    cdb_tag[p*TAG_W +: TAG_W] = tag;
    cdb_data[p*DATA_W +: DATA_W] = d;
  endtask
  task automatic cdb_clr();
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
  endtask
  task automatic drain(input string tag, input int budget);
    for (int n = 0; n < budget && q.size() != 0; n++) step();
    chk({tag, "_drain"}, 64'(q.size()), 64'd0);
    step();
  endtask
  always @(negedge clk)
    if (!rst && !flush && rdy && iss_valid && iss_ready) begin
      if (q.size() == 0) chk("unexpected_issue", 64'd1, 64'd0);
      else begin
        m_e = q.pop_front();
        chk("iss_op", 64'(iss_op), 64'(m_e.op));
        chk("iss_dest", 64'(iss_dest), 64'(m_e.dest));
        chk("iss_vi", 64'(iss_vi), 64'(m_e.vi));
        chk("iss_vj", 64'(iss_vj), 64'(m_e.vj));
        chk("iss_imm", 64'(iss_imm), 64'(m_e.imm));
        chk("iss_pc", 64'(iss_pc), 64'(m_e.pc));
      end
    end
  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; iss_ready = 1'b0; disp_valid = 1'b0;
    disp_op = '0; disp_dest = '0; disp_qi = '0; disp_qj = '0;
    disp_vi = '0; disp_vj = '0; disp_imm = '0; disp_pc = '0;
    cdb_clr();
    step(); step();
    rst = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_iss_dest", 64'(iss_dest), 64'd0);
    // single ready entry: one cycle of residency before issue
    iss_ready = 1'b1;
    expect_iss(6'd3, 4'd5, 32'd7, 32'd9);
    disp(6'd3, 4'd5, 4'd0, 4'd0, 32'd7, 32'd9);
    chk("t1_count_e1", 64'(count), 64'd1);
    chk("t1_valid_e1", 64'(iss_valid), 64'd0);
    step();
    chk("t1_valid_e2", 64'(iss_valid), 64'd1);
    chk("t1_count_e2", 64'(count), 64'd0);
    chk("t1_dest_e2", 64'(iss_dest), 64'd5);
    step();
    chk("t1_idle", 64'(iss_valid), 64'd0);
    // age order with wakeup on port 1
    expect_iss(6'd0, 4'd3, 32'h33, 32'd3);
    expect_iss(6'd0, 4'd1, 32'h55, 32'd1);
    expect_iss(6'd0, 4'd2, 32'h55, 32'd2);
    disp(6'd0, 4'd1, 4'd6, 4'd0, 32'd0, 32'd1);
    disp(6'd0, 4'd2, 4'd6, 4'd0, 32'd0, 32'd2);
    disp(6'd0, 4'd3, 4'd0, 4'd0, 32'h33, 32'd3);
    cdb_set(1, 4'd6, 32'h55);
    step();
    cdb_clr();
    drain("t2", 20);
    chk("t2_count", 64'(count), 64'd0);
    // dispatch-time forwarding
    expect_iss(6'd0, 4'd7, 32'd1, 32'hAB);
    cdb_set(0, 4'd4, 32'hAB);
    disp(6'd0, 4'd7, 4'd0, 4'd4, 32'd1, 32'd0);
    cdb_clr();
    step();
    chk("t3_fwd_valid", 64'(iss_valid), 64'd1);
    chk("t3_fwd_vj", 64'(iss_vj), 64'hAB);
    drain("t3a", 5);
    // tag-0 broadcasts must not disturb a ready source
    expect_iss(6'd0, 4'd8, 32'h22, 32'h33);
    cdb_set(0, 4'd0, 32'hFF);
    disp(6'd0, 4'd8, 4'd0, 4'd9, 32'h22, 32'd0);
    step();
    cdb_clr();
    cdb_set(1, 4'd9, 32'h33);
    step();
    cdb_clr();
    drain("t3b", 5);
    // back-pressure
    iss_ready = 1'b0;
    for (int i = 10; i < 13; i++) expect_iss(6'(i), 4'(i), 32'h100 + 32'(i), 32'h200 + 32'(i));
    for (int i = 10; i < 13; i++) disp(6'(i), 4'(i), 4'd0, 4'd0, 32'h100 + 32'(i), 32'h200 + 32'(i));
    step();
    chk("t4_hold_valid", 64'(iss_valid), 64'd1);
    chk("t4_hold_dest", 64'(iss_dest), 64'd10);
    chk("t4_hold_vi", 64'(iss_vi), 64'h10A);
    chk("t4_hold_count", 64'(count), 64'd2);
    step();
    chk("t4_hold_dest2", 64'(iss_dest), 64'd10);
    chk("t4_hold_count2", 64'(count), 64'd2);
    iss_ready = 1'b1;
    step();
    chk("t4_tp_dest1", 64'(iss_dest), 64'd11);
    chk("t4_tp_count1", 64'(count), 64'd1);
    step();
    chk("t4_tp_dest2", 64'(iss_dest), 64'd12);
    chk("t4_tp_count2", 64'(count), 64'd0);
    drain("t4", 3);
    chk("t4_idle", 64'(iss_valid), 64'd0);
    // full station
    for (int i = 0; i < DEPTH; i++)
      disp(6'(i), 4'(i), 4'(1 + i % 15), (i == 15) ? 4'd2 : 4'd0, 32'd0, 32'(i));
    chk("t5_full_count", 64'(count), 64'd16);
    chk("t5_full_ready", 64'(disp_ready), 64'd0);
    disp(6'd0, 4'd0, 4'd0, 4'd0, 32'd1, 32'd1);
    chk("t5_ignored_count", 64'(count), 64'd16);
    chk("t5_no_issue", 64'(iss_valid), 64'd0);
    expect_iss(6'd0, 4'd0, 32'h77, 32'd0);
    cdb_set(0, 4'd1, 32'h77);
    step();
    cdb_clr();
    chk("t5_woken_ready", 64'(disp_ready), 64'd0);
    chk("t5_woken_count", 64'(count), 64'd16);
    step();
    chk("t5_issue_count", 64'(count), 64'd15);
    chk("t5_issue_ready", 64'(disp_ready), 64'd1);
    chk("t5_issue_dest", 64'(iss_dest), 64'd0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_flush_count", 64'(count), 64'd0);
    // flush with a held issue and 10 pending entries
    iss_ready = 1'b0;
    disp(6'd1, 4'd1, 4'd0, 4'd0, 32'h11, 32'h12);
    for (int i = 2; i < 12; i++) disp(6'd0, 4'(i), 4'd3, 4'd0, 32'd0, 32'(i));
    step();
    chk("t6_pre_count", 64'(count), 64'd10);
    chk("t6_pre_valid", 64'(iss_valid), 64'd1);
    chk("t6_pre_dest", 64'(iss_dest), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t6_valid", 64'(iss_valid), 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_dest_clr", 64'(iss_dest), 64'd0);
    chk("t6_vi_clr", 64'(iss_vi), 64'd0);
    iss_ready = 1'b1;
    cdb_set(0, 4'd3, 32'h99);
    step();
    cdb_clr();
    repeat (4) step();
    chk("t6_post_valid", 64'(iss_valid), 64'd0);
    chk("t6_post_count", 64'(count), 64'd0);
    // rdy low freezes everything
    rdy = 1'b0;
    disp(6'd0, 4'd4, 4'd0, 4'd0, 32'd1, 32'd2);
    step();
    chk("t7_frz_count", 64'(count), 64'd0);
    chk("t7_frz_valid", 64'(iss_valid), 64'd0);
    rdy = 1'b1;
    step();
    chk("t7_count", 64'(count), 64'd0);
    chk("final_queue", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rs_age_ordered.md
Name: rs_age_ordered

Overview:
Parametrised reservation station that sits between the dispatcher and the ALU.
- Holds DEPTH entries waiting on up to two source operands, identified by ROB tags.
- Wakes entries from CDB_N broadcast ports, including same-cycle forwarding to the entry being dispatched.
- Issues the oldest ready entry to the ALU through a valid/ready handshake with a held output register.
- Adds over the previous station: configurable depth, tag width and CDB count; age-ordered selection; ALU back-pressure; an occupancy count.

Parameters:
DEPTH, 16, number of entries (power of 2, >=2)
TAG_W, 4, ROB tag width; tag 0 means "no dependency"
DATA_W, 32, operand/immediate/pc width
OPT_W, 6, instruction-type width
CDB_N, 2, number of result broadcast ports

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low freezes all state
flush  in  1  rollback from ROB; discards all contents
disp_valid  in  1  dispatch request
disp_ready  out  1  an entry is free (count < DEPTH)
disp_op  in  OPT_W  instruction type
disp_dest  in  TAG_W  ROB tag of result
disp_qi, disp_qj  in  TAG_W  source tags (0 = value valid)
disp_vi, disp_vj  in  DATA_W  source values
disp_imm, disp_pc  in  DATA_W  immediate, pc
cdb_valid  in  CDB_N  per-port valid
cdb_tag  in  CDB_N*TAG_W  packed tags, port k at bits [k*TAG_W +: TAG_W]
cdb_data  in  CDB_N*DATA_W  packed results
iss_valid  out  1  issue output valid
iss_ready  in  1  ALU accepts
iss_op, iss_dest, iss_vi, iss_vj, iss_imm, iss_pc  out  as disp_*  issued entry
count  out  clog2(DEPTH)+1  occupied entries, including none in flight at output

Behaviour:
- Reset/flush: at the edge where rst or flush is high, clear all entries, count, and iss_valid. Clear all iss_* fields to 0. rst and flush take priority over rdy. Reset is accepted at any time, including mid-handshake.
- rdy low: no state changes. Outputs hold.
- Allocation when disp_valid && disp_ready at the edge:
  - Write into the lowest-index free entry, evaluated on pre-edge state. A slot freed at the same edge is not reused.
  - Forwarding: if any cdb port has valid, tag == disp_q*, and tag != 0, store q*=0 and that port's data. On multiple hits, the lowest port index wins.
  - The new entry's rank = number of entries remaining after this edge's issue.
  - disp_valid with disp_ready low is ignored.
- Wakeup: for every occupied entry and every cdb port with valid and tag != 0, a matching q* is set to 0 and v* takes the data. Lowest port index wins. Wakeup is registered: an entry woken at edge E is eligible only after E.
- Eligibility: occupied && qi==0 && qj==0.
- Select: the eligible entry with the smallest rank (oldest).
- Issue advance condition: !iss_valid || iss_ready. When the condition holds at an edge:
  - If an eligible entry exists: load it into the iss_* register, set iss_valid=1, free the entry, and decrement the rank of every entry with a larger rank.
  - Otherwise: iss_valid=0. iss_* fields keep their old values.
- When iss_valid && !iss_ready: iss_* and iss_valid hold. No entry leaves.
- Latency: an entry dispatched ready at edge E gives iss_valid=1 after edge E+1 (minimum 1-cycle residency). Throughput is one issue per cycle.
- count: incremented on allocate, decremented on issue, unchanged when both happen. Wraps never; max DEPTH.
- Simultaneous events:
  - Dispatch, wakeup and issue can all occur in one edge.
  - A full station with an issue at the same edge still reports disp_ready=0 that cycle.
- Invariant: ranks of occupied entries are a permutation of 0..count-1.

Test Plan:
1. Reset, then dispatch op=3, dest=5, qi=qj=0, vi=7, vj=9 at edge 1 with iss_ready=1 -> iss_valid=1 after edge 2 with dest=5, vi=7, vj=9. count=1 after edge 1, 0 after edge 2.
2. Age order: dispatch A (dest 1, qi=6), B (dest 2, qi=6), C (dest 3, ready). Then cdb port1 broadcasts tag 6, data 0x55 -> issue order is C, A, B, with A.vi=B.vi=0x55.
3. Forwarding: dispatch qj=4 in the same cycle as cdb port0 valid tag 4, data 0xAB -> entry issues the next cycle with vj=0xAB. A broadcast with tag 0 does not wake a qi=0 entry's value.
4. Back-pressure: hold iss_ready=0 with 3 ready entries -> iss_valid stays 1 with the first entry's fields constant and count=2. Raise iss_ready -> one issue per cycle, oldest first.
5. Full: fill DEPTH=16 entries, all dependent -> disp_ready=0, and further disp_valid is ignored (count stays 16). Wake one entry -> it issues, and disp_ready=1 the following cycle.
6. Flush while iss_valid=1 and 10 entries are pending -> after the edge, iss_valid=0 and count=0. A subsequent cdb broadcast produces no issue.
